// File: rtl/lbist_pkg.sv
// -----------------------------------------------------------------------------
// lbist_pkg
// Shared definitions for the logic-BIST controller:
//   - state_e          : controller FSM state encoding
//   - DEF_POLY_A/B     : default tap masks of the input-vector and scan-fill LFSRs
//   - DEF_SEED_A/B     : default nonzero reseed values of those LFSRs
//   - DEF_MISR_POLY    : default MISR feedback mask
//   - DEF_GOLDEN       : default expected signature
// -----------------------------------------------------------------------------
package lbist_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    CAPTURE = 3'd2,
    UNLOAD  = 3'd3,
    COMPARE = 3'd4,
    DONE    = 3'd5
  } state_e;

  localparam logic [7:0] DEF_POLY_A    = 8'hB8;
  localparam logic [7:0] DEF_POLY_B    = 8'h8E;
  localparam logic [7:0] DEF_SEED_A    = 8'h01;
  localparam logic [7:0] DEF_SEED_B    = 8'h5A;
  localparam logic [7:0] DEF_MISR_POLY = 8'h1D;
  localparam logic [7:0] DEF_GOLDEN    = 8'h00;

endpackage

// File: rtl/lbist_ctrl_if.sv
// -----------------------------------------------------------------------------
// lbist_ctrl_if
// Connection between the BIST controller and the circuit under test (CUT).
//   cut_in   : CUT functional inputs        (controller -> CUT)
//   scan_en  : CUT scan enable               (controller -> CUT)
//   scan_in  : scan chain serial input       (controller -> CUT)
//   cut_out  : CUT primary outputs           (CUT -> controller)
//   scan_out : scan chain serial output      (CUT -> controller)
// Modports: master = controller side, slave = CUT side.
// -----------------------------------------------------------------------------
interface lbist_ctrl_if #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 2
);

  logic [N_IN-1:0]  cut_in;
  logic [N_OUT-1:0] cut_out;
  logic             scan_en;
  logic             scan_in;
  logic             scan_out;

  modport master (
    output cut_in,
    output scan_en,
    output scan_in,
    input  cut_out,
    input  scan_out
  );

  modport slave (
    input  cut_in,
    input  scan_en,
    input  scan_in,
    output cut_out,
    output scan_out
  );

endinterface

// File: rtl/lbist_lfsr.sv
// -----------------------------------------------------------------------------
// lbist_lfsr
// Fibonacci LFSR: shifts left, new LSB = XOR of the bits selected by POLY.
// Ports:
//   CLK    : clock, rising edge
//   RST    : synchronous active-high reset, loads SEED
//   reseed : load SEED on the next edge (has priority over en)
//   en     : advance one step on the next edge
//   q      : current LFSR value
// -----------------------------------------------------------------------------
module lbist_lfsr
  import lbist_pkg::*;
#(
  parameter int           W    = 8,
  parameter logic [W-1:0] POLY = W'(DEF_POLY_A),
  parameter logic [W-1:0] SEED = W'(DEF_SEED_A)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         reseed,
  input  logic         en,
  output logic [W-1:0] q
);

  if (W < 2) begin : g_chk_width
    $error("lbist_lfsr: W must be at least 2");
  end

  logic [W-1:0] lfsr_d;
  logic [W-1:0] lfsr_q;

  // Next-value selection: reseed, step, or hold.
  always_comb begin
    lfsr_d = lfsr_q;
    if (reseed) begin
      lfsr_d = SEED;
    end else if (en) begin
      lfsr_d = {lfsr_q[W-2:0], ^(lfsr_q & POLY)};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/lbist_ctrl.sv
// -----------------------------------------------------------------------------
// lbist_ctrl
// Logic-BIST controller: loads the scan chain from a pseudo-random LFSR,
// applies pseudo-random functional inputs in a one-cycle capture, compacts
// the CUT responses into a MISR and compares the final signature.
//
// Ports:
//   CLK        : clock, rising edge
//   RST        : synchronous active-high reset
//   bist_start : test request (level); sampled into a request flop, the
//                test begins on the following edge
//   bist_abort : abort request (only acted on when LBIST_ABORT_EN is defined)
//   func_in    : functional inputs, passed to the CUT while IDLE/DONE
//   cut_if     : CUT connection (cut_in, scan_en, scan_in, cut_out, scan_out)
//   bist_busy  : test in progress (SHIFT/CAPTURE/UNLOAD/COMPARE)
//   bist_end   : test finished, held in DONE
//   pass_fail  : 1 = signature matched GOLDEN, valid in DONE
//   signature  : current MISR value
//
// Build option: define LBIST_ABORT_EN to let bist_abort cancel a running test.
// -----------------------------------------------------------------------------
module lbist_ctrl
  import lbist_pkg::*;
#(
  parameter int                N_IN      = 3,
  parameter int                N_OUT     = 2,
  parameter int                SCAN_LEN  = 8,
  parameter int                N_PAT     = 16,
  parameter int                LFSR_W    = 8,
  parameter logic [LFSR_W-1:0] POLY_A    = LFSR_W'(DEF_POLY_A),
  parameter logic [LFSR_W-1:0] POLY_B    = LFSR_W'(DEF_POLY_B),
  parameter logic [LFSR_W-1:0] SEED_A    = LFSR_W'(DEF_SEED_A),
  parameter logic [LFSR_W-1:0] SEED_B    = LFSR_W'(DEF_SEED_B),
  parameter int                MISR_W    = 8,
  parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(DEF_MISR_POLY),
  parameter logic [MISR_W-1:0] GOLDEN    = MISR_W'(DEF_GOLDEN)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              bist_start,
  input  logic              bist_abort,
  input  logic [N_IN-1:0]   func_in,
  lbist_ctrl_if.master      cut_if,
  output logic              bist_busy,
  output logic              bist_end,
  output logic              pass_fail,
  output logic [MISR_W-1:0] signature
);

  // Parameter sanity checks at elaboration.
  if (N_OUT + 1 > MISR_W) begin : g_chk_misr_w
    $error("lbist_ctrl: MISR_W must be at least N_OUT+1");
  end
  if (N_IN > LFSR_W) begin : g_chk_n_in
    $error("lbist_ctrl: N_IN must not exceed LFSR_W");
  end
  if (SCAN_LEN < 1) begin : g_chk_scan_len
    $error("lbist_ctrl: SCAN_LEN must be at least 1");
  end
  if (N_PAT < 1) begin : g_chk_n_pat
    $error("lbist_ctrl: N_PAT must be at least 1");
  end
  if (POLY_A == POLY_B) begin : g_chk_poly
    $error("lbist_ctrl: POLY_A and POLY_B must differ");
  end

  localparam int BCW = $clog2(SCAN_LEN + 1);
  localparam int PCW = $clog2(N_PAT + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(SCAN_LEN - 1);
  localparam logic [PCW-1:0] PAT_LAST = PCW'(N_PAT - 1);

  // One MISR step: shift, fold back the MSB through the feedback mask,
  // and XOR in the parallel response word.
  function automatic logic [MISR_W-1:0] misr_step(
    input logic [MISR_W-1:0] m,
    input logic [MISR_W-1:0] din
  );
    logic [MISR_W-1:0] fb;
    fb = m[MISR_W-1] ? MISR_POLY : {MISR_W{1'b0}};
    return {m[MISR_W-2:0], 1'b0} ^ fb ^ din;
  endfunction

  state_e            state_q, state_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [PCW-1:0]    pat_cnt_q, pat_cnt_d;
  logic [MISR_W-1:0] misr_q, misr_d;
  logic              start_q, start_d;
  logic              bist_end_q, bist_end_d;
  logic              pass_fail_q, pass_fail_d;

  logic              reseed_s;
  logic              lfsr_a_en_s;
  logic              lfsr_b_en_s;
  logic [LFSR_W-1:0] lfsr_a_val_s;
  logic [LFSR_W-1:0] lfsr_b_val_s;
  logic [MISR_W-1:0] misr_in_s;
  logic [MISR_W-1:0] misr_upd_s;
  logic              idle_like_s;
  logic              busy_s;
  logic              abort_s;
  logic              misc_unused_s;

  lbist_lfsr #(
    .W    (LFSR_W),
    .POLY (POLY_A),
    .SEED (SEED_A)
  ) u_lfsr_a (
    .CLK    (CLK),
    .RST    (RST),
    .reseed (reseed_s),
    .en     (lfsr_a_en_s),
    .q      (lfsr_a_val_s)
  );

  lbist_lfsr #(
    .W    (LFSR_W),
    .POLY (POLY_B),
    .SEED (SEED_B)
  ) u_lfsr_b (
    .CLK    (CLK),
    .RST    (RST),
    .reseed (reseed_s),
    .en     (lfsr_b_en_s),
    .q      (lfsr_b_val_s)
  );

  assign idle_like_s = (state_q == IDLE) || (state_q == DONE);
  assign busy_s      = !idle_like_s;

  // Response word: scan_out in bit 0, CUT outputs above it, zero-extended.
  assign misr_in_s  = MISR_W'({cut_if.cut_out, cut_if.scan_out});
  assign misr_upd_s = misr_step(misr_q, misr_in_s);

`ifdef LBIST_ABORT_EN
  assign abort_s = bist_abort & busy_s;
`else
  assign abort_s = 1'b0;
`endif

  // Bits with no functional use (abort in the default build, upper LFSR bits).
  assign misc_unused_s = ^{bist_abort, lfsr_a_val_s, lfsr_b_val_s};

  assign start_d = bist_start;

  // FSM next state, counters, MISR and status next values.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    pat_cnt_d   = pat_cnt_q;
    misr_d      = misr_q;
    bist_end_d  = bist_end_q;
    pass_fail_d = pass_fail_q;
    reseed_s    = 1'b0;
    lfsr_a_en_s = 1'b0;
    lfsr_b_en_s = 1'b0;

    if (abort_s) begin
      state_d     = IDLE;
      bit_cnt_d   = {BCW{1'b0}};
      pat_cnt_d   = {PCW{1'b0}};
      misr_d      = {MISR_W{1'b0}};
      bist_end_d  = 1'b0;
      pass_fail_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          // A pending request starts a fresh test; otherwise results are held.
          if (start_q) begin
            state_d     = SHIFT;
            reseed_s    = 1'b1;
            bit_cnt_d   = {BCW{1'b0}};
            pat_cnt_d   = {PCW{1'b0}};
            misr_d      = {MISR_W{1'b0}};
            bist_end_d  = 1'b0;
            pass_fail_d = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        SHIFT: begin
          lfsr_b_en_s = 1'b1;
          // The chain holds unknown data while the first pattern is loaded.
          if (pat_cnt_q != {PCW{1'b0}}) begin
            misr_d = misr_upd_s;
          end else begin
            misr_d = misr_q;
          end
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = {BCW{1'b0}};
            state_d   = CAPTURE;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
        CAPTURE: begin
          lfsr_a_en_s = 1'b1;
          misr_d      = misr_upd_s;
          pat_cnt_d   = pat_cnt_q + PCW'(1);
          if (pat_cnt_q == PAT_LAST) begin
            state_d = UNLOAD;
          end else begin
            state_d = SHIFT;
          end
        end
        UNLOAD: begin
          misr_d = misr_upd_s;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = {BCW{1'b0}};
            state_d   = COMPARE;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
        COMPARE: begin
          pass_fail_d = (misr_q == GOLDEN);
          bist_end_d  = 1'b1;
          state_d     = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Controller state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      bit_cnt_q   <= {BCW{1'b0}};
      pat_cnt_q   <= {PCW{1'b0}};
      misr_q      <= {MISR_W{1'b0}};
      start_q     <= 1'b0;
      bist_end_q  <= 1'b0;
      pass_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      pat_cnt_q   <= pat_cnt_d;
      misr_q      <= misr_d;
      start_q     <= start_d;
      bist_end_q  <= bist_end_d;
      pass_fail_q <= pass_fail_d;
    end
  end

  // Outputs are pure decodes of registered state, so they switch only on edges
  // (cut_in additionally passes func_in straight through while IDLE/DONE).
  assign cut_if.scan_en = (state_q == SHIFT) || (state_q == UNLOAD);
  assign cut_if.scan_in = (state_q == SHIFT) ? lfsr_b_val_s[LFSR_W-1] : 1'b0;
  assign cut_if.cut_in  = idle_like_s ? func_in : lfsr_a_val_s[N_IN-1:0];

  assign bist_busy = busy_s;
  assign bist_end  = bist_end_q;
  assign pass_fail = pass_fail_q;
  assign signature = misr_q;

endmodule

// File: tb/tb_lbist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lbist_ctrl
// Bench for lbist_ctrl with a behavioural scan CUT (8-flop chain plus a small
// combinational output function). The expected signature is computed by an
// independent model of the whole test sequence.
// -----------------------------------------------------------------------------
module tb_lbist_ctrl;
  import lbist_pkg::*;

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_lfsr(input logic [7:0] q, input logic [7:0] poly);
    return {q[6:0], ^(q & poly)};
  endfunction

  function automatic logic [7:0] m_misr(input logic [7:0] m, input logic [7:0] d);
    return {m[6:0], 1'b0} ^ (m[7] ? 8'h1D : 8'h00) ^ d;
  endfunction

  function automatic logic [1:0] cut_fn(input logic [2:0] ci, input logic [7:0] ch,
                                        input logic stuck);
    logic [1:0] r;
    r[1] = ch[0] ^ ci[2] ^ ci[1];
    r[0] = stuck ? 1'b0 : ((ch[3] & ci[0]) | ch[5]);
    return r;
  endfunction

  function automatic logic [7:0] cap_fn(input logic [7:0] ch, input logic [2:0] ci);
    return {ch[6:0], ch[7]} ^ {ci, ci[1:0], ci};
  endfunction

  function automatic logic [7:0] model_sig(input logic stuck);
    logic [7:0] a, b, m, ch;
    logic [1:0] co;
    a = 8'h01; b = 8'h5A; m = 8'h00; ch = 8'h00;
    for (int p = 0; p < 16; p++) begin
      for (int s = 0; s < 8; s++) begin
        co = cut_fn(a[2:0], ch, stuck);
        if (p != 0) m = m_misr(m, {5'b00000, co, ch[7]});
        ch = {ch[6:0], b[7]};
        b  = m_lfsr(b, 8'h8E);
      end
      co = cut_fn(a[2:0], ch, stuck);
      m  = m_misr(m, {5'b00000, co, ch[7]});
      ch = cap_fn(ch, a[2:0]);
      a  = m_lfsr(a, 8'hB8);
    end
    for (int s = 0; s < 8; s++) begin
      co = cut_fn(a[2:0], ch, stuck);
      m  = m_misr(m, {5'b00000, co, ch[7]});
      ch = {ch[6:0], 1'b0};
    end
    return m;
  endfunction

  localparam logic [7:0] GOLD = model_sig(1'b0);
  localparam int         LAT  = 154;

  // ---------------- DUT + CUT ----------------
  logic       clk, rst, bist_start, bist_abort, fault_en;
  logic [2:0] func_in;
  logic       bist_busy, bist_end, pass_fail;
  logic [7:0] signature;
  logic [7:0] chain_q;

  lbist_ctrl_if #(.N_IN(3), .N_OUT(2)) bus ();

  lbist_ctrl #(.GOLDEN(GOLD)) dut (
    .CLK        (clk),
    .RST        (rst),
    .bist_start (bist_start),
    .bist_abort (bist_abort),
    .func_in    (func_in),
    .cut_if     (bus),
    .bist_busy  (bist_busy),
    .bist_end   (bist_end),
    .pass_fail  (pass_fail),
    .signature  (signature)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.scan_en) chain_q <= {chain_q[6:0], bus.scan_in};
    else             chain_q <= cap_fn(chain_q, bus.cut_in);
  end
  assign bus.cut_out  = cut_fn(bus.cut_in, chain_q, fault_en);
  assign bus.scan_out = chain_q[7];

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [7:0] sig;
    logic       pf;
    int         lat;
  } exp_t;
  exp_t sb_q[$];

  logic       obs_busy  [0:300];
  logic       obs_end   [0:300];
  logic       obs_sen   [0:300];
  logic       obs_sin   [0:300];
  logic [2:0] obs_cin   [0:300];
  logic [7:0] obs_sig   [0:300];
  logic [2:0] obs_state [0:300];
  int         run_lat;

  // Start a test (start sampled at edge k) and record outputs after each of
  // the following edges k+i; run_lat = first i where bist_end rose.
  task automatic do_run(input int hold, input int abort_at, input int rst_at,
                        input int max_cyc);
    logic seen_low;
    seen_low = 1'b0;
    run_lat  = -1;
    @(negedge clk);
    bist_start = 1'b1;
    @(posedge clk); #1;
    bist_start = (1 < hold);
    bist_abort = (1 == abort_at);
    rst        = (1 == rst_at);
    for (int i = 1; i <= max_cyc && run_lat < 0; i++) begin
      @(posedge clk); #1;
      bist_start = (i + 1 < hold);
      bist_abort = (i + 1 == abort_at);
      rst        = (i + 1 == rst_at);
      @(negedge clk);
      obs_busy[i]  = bist_busy;
      obs_end[i]   = bist_end;
      obs_sen[i]   = bus.scan_en;
      obs_sin[i]   = bus.scan_in;
      obs_cin[i]   = bus.cut_in;
      obs_sig[i]   = signature;
      obs_state[i] = dut.state_q;
      if (!bist_end)     seen_low = 1'b1;
      else if (seen_low) run_lat  = i;
    end
    bist_start = 1'b0;
    bist_abort = 1'b0;
    rst        = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bist_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bist_busy); else passes++;
    checks++; if (bist_end !== 1'b0) $display("FAIL reset_end: got %b expected 0", bist_end); else passes++;
    checks++; if (pass_fail !== 1'b0) $display("FAIL reset_pf: got %b expected 0", pass_fail); else passes++;
    checks++; if (signature !== 8'h00) $display("FAIL reset_sig: got %h expected 00", signature); else passes++;
    checks++; if (bus.scan_en !== 1'b0) $display("FAIL reset_scan_en: got %b expected 0", bus.scan_en); else passes++;
  endtask

  task automatic test_idle_passthru();
    logic [2:0] pats [2];
    pats[0] = 3'b101;
    pats[1] = 3'b010;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      func_in = pats[i];
      #1;
      checks++; if (bus.cut_in !== pats[i]) $display("FAIL idle_cut_in: got %b expected %b", bus.cut_in, pats[i]); else passes++;
      checks++; if (bus.scan_en !== 1'b0) $display("FAIL idle_scan_en: got %b expected 0", bus.scan_en); else passes++;
    end
  endtask

  task automatic test_golden_run();
    exp_t e;
    logic [7:0] b, a;
    e.sig = GOLD; e.pf = 1'b1; e.lat = LAT;
    sb_q.push_back(e);
    do_run(1, 0, 0, 200);
    e = sb_q.pop_front();
    checks++; if (run_lat !== e.lat) $display("FAIL golden_latency: got %0d expected %0d", run_lat, e.lat); else passes++;
    checks++; if (signature !== e.sig) $display("FAIL golden_sig: got %h expected %h", signature, e.sig); else passes++;
    checks++; if (pass_fail !== e.pf) $display("FAIL golden_pf: got %b expected %b", pass_fail, e.pf); else passes++;
    checks++; if (bist_busy !== 1'b0) $display("FAIL golden_done_busy: got %b expected 0", bist_busy); else passes++;
    b = 8'h5A;
    checks++; if (obs_busy[1] !== 1'b1 || obs_sen[1] !== 1'b1) $display("FAIL shift_entry: busy %b scan_en %b expected 1 1", obs_busy[1], obs_sen[1]); else passes++;
    checks++; if (obs_sin[1] !== b[7]) $display("FAIL scan_in_1: got %b expected %b", obs_sin[1], b[7]); else passes++;
    b = m_lfsr(b, 8'h8E);
    checks++; if (obs_sin[2] !== b[7]) $display("FAIL scan_in_2: got %b expected %b", obs_sin[2], b[7]); else passes++;
    a = 8'h01;
    checks++; if (obs_sen[9] !== 1'b0 || obs_cin[9] !== a[2:0]) $display("FAIL capture_1: scan_en %b cut_in %b expected 0 %b", obs_sen[9], obs_cin[9], a[2:0]); else passes++;
    a = m_lfsr(a, 8'hB8);
    checks++; if (obs_cin[18] !== a[2:0]) $display("FAIL capture_2: got %b expected %b", obs_cin[18], a[2:0]); else passes++;
    checks++; if (obs_end[153] !== 1'b0) $display("FAIL end_early: got %b expected 0", obs_end[153]); else passes++;
  endtask

  task automatic test_restart_held();
    exp_t e;
    e.sig = GOLD; e.pf = 1'b1; e.lat = LAT;
    sb_q.push_back(e);
    do_run(100, 0, 0, 200);
    e = sb_q.pop_front();
    checks++; if (run_lat !== e.lat) $display("FAIL restart_latency: got %0d expected %0d", run_lat, e.lat); else passes++;
    checks++; if (signature !== e.sig) $display("FAIL restart_sig: got %h expected %h", signature, e.sig); else passes++;
    checks++; if (pass_fail !== e.pf) $display("FAIL restart_pf: got %b expected %b", pass_fail, e.pf); else passes++;
    checks++; if (obs_busy[120] !== 1'b1) $display("FAIL restart_busy: got %b expected 1", obs_busy[120]); else passes++;
  endtask

  task automatic test_stuck_fault();
    exp_t e;
    e.sig = model_sig(1'b1); e.pf = (e.sig == GOLD); e.lat = LAT;
    sb_q.push_back(e);
    fault_en = 1'b1;
    do_run(1, 0, 0, 200);
    fault_en = 1'b0;
    e = sb_q.pop_front();
    checks++; if (run_lat !== e.lat) $display("FAIL stuck_latency: got %0d expected %0d", run_lat, e.lat); else passes++;
    checks++; if (signature !== e.sig) $display("FAIL stuck_sig: got %h expected %h", signature, e.sig); else passes++;
    checks++; if (pass_fail !== e.pf) $display("FAIL stuck_pf: got %b expected %b", pass_fail, e.pf); else passes++;
  endtask

  task automatic test_mid_reset();
    state_e exp_st;
    exp_st = IDLE;
    do_run(1, 0, 50, 60);
    checks++; if (obs_busy[49] !== 1'b1) $display("FAIL mid_rst_running: got %b expected 1", obs_busy[49]); else passes++;
    checks++; if (obs_busy[50] !== 1'b0) $display("FAIL mid_rst_busy: got %b expected 0", obs_busy[50]); else passes++;
    checks++; if (obs_sig[50] !== 8'h00) $display("FAIL mid_rst_sig: got %h expected 00", obs_sig[50]); else passes++;
    checks++; if (obs_state[50] !== exp_st) $display("FAIL mid_rst_state: got %0d expected %0d", obs_state[50], exp_st); else passes++;
    checks++; if (obs_sen[50] !== 1'b0 || obs_end[50] !== 1'b0) $display("FAIL mid_rst_outs: scan_en %b end %b expected 0 0", obs_sen[50], obs_end[50]); else passes++;
  endtask

  task automatic test_abort();
`ifdef LBIST_ABORT_EN
    int end_seen;
    do_run(1, 20, 0, 60);
    end_seen = 0;
    for (int i = 20; i <= 60; i++) if (obs_end[i] !== 1'b0) end_seen++;
    checks++; if (obs_busy[19] !== 1'b1) $display("FAIL abort_running: got %b expected 1", obs_busy[19]); else passes++;
    checks++; if (obs_busy[20] !== 1'b0) $display("FAIL abort_busy: got %b expected 0", obs_busy[20]); else passes++;
    checks++; if (obs_sig[20] !== 8'h00) $display("FAIL abort_sig: got %h expected 00", obs_sig[20]); else passes++;
    checks++; if (end_seen !== 0) $display("FAIL abort_end: got %0d cycles with end expected 0", end_seen); else passes++;
`else
    exp_t e;
    e.sig = GOLD; e.pf = 1'b1; e.lat = LAT;
    sb_q.push_back(e);
    do_run(1, 20, 0, 200);
    e = sb_q.pop_front();
    checks++; if (run_lat !== e.lat) $display("FAIL abort_ignored_latency: got %0d expected %0d", run_lat, e.lat); else passes++;
    checks++; if (signature !== e.sig) $display("FAIL abort_ignored_sig: got %h expected %h", signature, e.sig); else passes++;
    checks++; if (pass_fail !== e.pf) $display("FAIL abort_ignored_pf: got %b expected %b", pass_fail, e.pf); else passes++;
`endif
  endtask

  initial begin
    rst = 1'b1; bist_start = 1'b0; bist_abort = 1'b0; fault_en = 1'b0;
    func_in = 3'b000;
    test_reset();
    test_idle_passthru();
    test_golden_run();
    test_restart_held();
    test_stuck_fault();
    test_mid_reset();
    test_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
